vga_sync_decoder: RTL and testbench
===================================

# vga_sync_decoder

Receive-side VGA timing recovery for the display path. Samples an incoming active-low hsync/vsync pair in the pixel-clock domain and rebuilds the pixel position (x_loc, y_loc) and the video-active flag. Checks line and frame periods against the configured mode and reports lock state and sync errors. It sits at the input of any block that consumes a VGA-timed stream, such as a capture or overlay stage.

## Interface
- H_display, 640, visible pixels per line
- H_front_porch, 16, clocks from end of display to hsync fall
- H_sync_width, 96, hsync low width
- H_back_porch, 48, clocks from hsync rise to next line
- V_display, 480, visible lines per frame
- V_front_porch, 10, lines from end of display to vsync fall
- V_sync_width, 2, vsync low width in lines
- V_back_porch, 33, lines from vsync rise to next frame
- LOCK_FRAMES, 2, consecutive good frames required for lock (1..15)
- clk  input  1  pixel clock; single clock domain
- reset  input  1  synchronous, active-high
- hsync_in  input  1  incoming horizontal sync, active low
- vsync_in  input  1  incoming vertical sync, active low
- x_loc  output  16  recovered horizontal position
- y_loc  output  16  recovered vertical position
- video  output  1  high when locked and position is inside the visible area
- locked  output  1  high in the LOCKED state
- frame_start  output  1  one-clock pulse when locked and x_loc==0 and y_loc==0
- sync_err  output  1  one-clock pulse when lock is lost

## Operation
- Derived constants:
  - H_TOTAL = sum of the four H_* parameters (800).
  - V_TOTAL = sum of the four V_* parameters (525).
  - H_SS = H_display + H_front_porch (656).
  - V_SS = V_display + V_front_porch (490).
- Edge detect:
  - hs_d/vs_d register the inputs; both reset to 1.
  - hfall = hs_d & ~hsync_in.
  - vfall = vs_d & ~vsync_in.
- Position counters (hcnt, vcnt):
  - hcnt increments each clock and wraps H_TOTAL-1 -> 0.
  - vcnt increments on each hcnt wrap and wraps V_TOTAL-1 -> 0.
  - hfall loads hcnt <= H_SS.
  - vfall loads vcnt <= V_SS.
  - If vfall and an hcnt wrap occur together, the vfall load wins.
- Outputs: x_loc = hcnt and y_loc = vcnt.
- video = locked && hcnt < H_display && vcnt < V_display.
- Period checks:
  - hper counts clocks since the last hfall. It clears to 0 on hfall and saturates at 0xFFFF.
  - A line is good when hper == H_TOTAL-1 at hfall.
  - vper counts hfalls since the last vfall and clears on vfall.
  - A frame is good when vper == V_TOTAL at vfall.
- Timeout: hper reaching 2*H_TOTAL counts as a bad line.
- State machine (reset: SEARCH):
  - SEARCH: the first vfall moves to ACQUIRE and sets good_cnt = 0.
  - ACQUIRE:
    - A bad line or timeout moves to SEARCH.
    - On vfall with a good frame, good_cnt+1; when good_cnt reaches LOCK_FRAMES, move to LOCKED.
    - On vfall with a bad frame, good_cnt = 0 and the state stays ACQUIRE.
  - LOCKED:
    - A bad line, bad frame or timeout moves to SEARCH and pulses sync_err (see Configuration for the bad-line case).
- Reset values of all outputs are 0. Internal counters, good_cnt and miss_cnt are also 0.

## Timing
- Outputs are registered.
- An edge first present on hsync_in/vsync_in at clock edge N is reflected in x_loc/y_loc after edge N:
  - x_loc = 656 after an hsync edge.
  - y_loc = 490 after a vsync edge.
- Steady state: x_loc/y_loc equal the source hcount/vcount delayed by 1 clock.
- locked rises 1 clock after the vfall that completes LOCK_FRAMES good frames. With the default of 2, that is the 3rd vfall after reset on a clean stream.
- On loss of lock:
  - sync_err is high for exactly 1 clock.
  - locked and video fall on the same clock.
- Reset mid-operation: on the next clock every output is 0 and the state is SEARCH. Reacquisition restarts from scratch.

## Configuration
- VGA_DEC_FLYWHEEL_EN defined:
  - In LOCKED, hfall and vfall do not reload hcnt/vcnt; the counters coast.
  - A bad line increments miss_cnt and a good line clears it.
  - Lock is dropped only when miss_cnt reaches 4 consecutive bad lines, or on a bad frame or timeout.
- VGA_DEC_FLYWHEEL_EN undefined:
  - Counters always reload on hfall/vfall.
  - Any single bad line in LOCKED drops to SEARCH with sync_err.

## Test plan
- Reset held 3 clocks with inputs high -> x_loc=0, y_loc=0, video=0, locked=0, sync_err=0.
- Clean 640x480 stream (800x525) -> locked rises 1 clock after the 3rd vfall. Then x_loc/y_loc track the source with 1-clock delay, video is high for exactly 307200 clocks per frame, and frame_start pulses once per frame.
- Locked, one hsync pulse early by 5 clocks:
  - Without the macro: sync_err pulses and locked=0.
  - With the macro: locked stays 1 and x_loc continues 0..799 unperturbed.
- Locked, hsync held high -> sync_err pulses when hper hits 1600 and the state returns to SEARCH.
- ACQUIRE with a 524-line frame -> good_cnt clears and locked rises at the 4th vfall instead of the 3rd.
- Reset asserted mid-frame while locked -> all outputs 0 on the next clock, and relock 1 clock after the 3rd subsequent vfall.

Source files
------------

// File: rtl/vga_sync_decoder.sv
// Receive-side VGA timing recovery: rebuilds x/y position, video-active and lock state
// from an active-low hsync/vsync pair. Define VGA_DEC_FLYWHEEL_EN to let counters coast while locked.
module vga_sync_decoder #(
    parameter int H_display     = 640,
    parameter int H_front_porch = 16,
    parameter int H_sync_width  = 96,
    parameter int H_back_porch  = 48,
    parameter int V_display     = 480,
    parameter int V_front_porch = 10,
    parameter int V_sync_width  = 2,
    parameter int V_back_porch  = 33,
    parameter int LOCK_FRAMES   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hsync_in,
    input  logic        vsync_in,
    output logic [15:0] x_loc,
    output logic [15:0] y_loc,
    output logic        video,
    output logic        locked,
    output logic        frame_start,
    output logic        sync_err
);
    localparam int H_TOTAL = H_display + H_front_porch + H_sync_width + H_back_porch;
    localparam int V_TOTAL = V_display + V_front_porch + V_sync_width + V_back_porch;

    localparam logic [15:0] H_LAST    = 16'(H_TOTAL - 1);
    localparam logic [15:0] V_LAST    = 16'(V_TOTAL - 1);
    localparam logic [15:0] H_SS      = 16'(H_display + H_front_porch);
    localparam logic [15:0] V_SS      = 16'(V_display + V_front_porch);
    localparam logic [15:0] H_TIMEOUT = 16'(2 * H_TOTAL);
    localparam logic [15:0] V_FULL    = 16'(V_TOTAL);
    localparam logic [15:0] H_DISP    = 16'(H_display);
    localparam logic [15:0] V_DISP    = 16'(V_display);
    localparam logic [3:0]  LOCK_N    = 4'(LOCK_FRAMES);

    localparam logic [1:0] ST_SEARCH  = 2'd0;
    localparam logic [1:0] ST_ACQUIRE = 2'd1;
    localparam logic [1:0] ST_LOCKED  = 2'd2;

    logic        hs_d_reg, vs_d_reg;
    logic [15:0] hcnt_reg, hcnt_next;
    logic [15:0] vcnt_reg, vcnt_next;
    logic [15:0] hper_reg, hper_next;
    logic [15:0] vper_reg, vper_next;
    logic [1:0]  state_reg, state_next;
    logic [3:0]  good_cnt_reg, good_cnt_next;
    logic        locked_reg, video_reg, frame_start_reg, sync_err_reg;
    logic        locked_next, video_next, frame_start_next, sync_err_next;

    logic hfall, vfall, coast, h_load, v_load, h_wrap, v_step;
    logic line_ok, bad_line, line_drop, timeout, frame_ok;

    assign hfall    = hs_d_reg & ~hsync_in;
    assign vfall    = vs_d_reg & ~vsync_in;
    assign line_ok  = (hper_reg == H_LAST);
    assign bad_line = hfall && !line_ok;
    assign timeout  = (hper_reg == H_TIMEOUT);
    assign frame_ok = (vper_reg == V_FULL);

`ifdef VGA_DEC_FLYWHEEL_EN
    // While locked, syncs only feed the period checks; lock survives up to 3 consecutive bad lines.
    logic [2:0] miss_cnt_reg, miss_cnt_next;

    assign coast = (state_reg == ST_LOCKED);

    always_comb begin
        miss_cnt_next = '0;
        line_drop     = 1'b0;
        if (state_reg == ST_LOCKED) begin
            miss_cnt_next = miss_cnt_reg;
            if (hfall) begin
                miss_cnt_next = line_ok ? 3'd0 : miss_cnt_reg + 3'd1;
                line_drop     = !line_ok && (miss_cnt_reg == 3'd3);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            miss_cnt_reg <= '0;
        end else begin
            miss_cnt_reg <= miss_cnt_next;
        end
    end
`else
    assign coast     = 1'b0;
    assign line_drop = bad_line;
`endif

    assign h_load = hfall && !coast;
    assign v_load = vfall && !coast;
    assign h_wrap = (hcnt_reg == H_LAST);
    assign v_step = h_wrap && !h_load;

    always_comb begin
        hcnt_next = h_wrap ? 16'd0 : hcnt_reg + 16'd1;
        if (h_load) begin
            hcnt_next = H_SS;
        end
        vcnt_next = vcnt_reg;
        if (v_load) begin
            vcnt_next = V_SS;
        end else if (v_step) begin
            vcnt_next = (vcnt_reg == V_LAST) ? 16'd0 : vcnt_reg + 16'd1;
        end
    end

    // Line period in clocks and frame period in lines, both measured sync-to-sync.
    always_comb begin
        hper_next = (hper_reg == 16'hFFFF) ? hper_reg : hper_reg + 16'd1;
        if (hfall) begin
            hper_next = 16'd0;
        end
        vper_next = vper_reg;
        if (vfall) begin
            vper_next = {15'd0, hfall};
        end else if (hfall && vper_reg != 16'hFFFF) begin
            vper_next = vper_reg + 16'd1;
        end
    end

    always_comb begin
        state_next    = state_reg;
        good_cnt_next = good_cnt_reg;
        sync_err_next = 1'b0;
        case (state_reg)
            ST_SEARCH: begin
                if (vfall) begin
                    state_next    = ST_ACQUIRE;
                    good_cnt_next = '0;
                end
            end
            ST_ACQUIRE: begin
                if (bad_line || timeout) begin
                    state_next = ST_SEARCH;
                end else if (vfall) begin
                    if (frame_ok) begin
                        good_cnt_next = good_cnt_reg + 4'd1;
                        if (good_cnt_reg + 4'd1 == LOCK_N) begin
                            state_next = ST_LOCKED;
                        end
                    end else begin
                        good_cnt_next = '0;
                    end
                end
            end
            ST_LOCKED: begin
                if (line_drop || timeout || (vfall && !frame_ok)) begin
                    state_next    = ST_SEARCH;
                    sync_err_next = 1'b1;
                end
            end
            default: state_next = ST_SEARCH;
        endcase
    end

    // Status outputs are derived from next-state values so they line up with x_loc/y_loc.
    assign locked_next      = (state_next == ST_LOCKED);
    assign video_next       = locked_next && (hcnt_next < H_DISP) && (vcnt_next < V_DISP);
    assign frame_start_next = locked_next && (hcnt_next == 16'd0) && (vcnt_next == 16'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            hs_d_reg        <= 1'b1;
            vs_d_reg        <= 1'b1;
            hcnt_reg        <= '0;
            vcnt_reg        <= '0;
            hper_reg        <= '0;
            vper_reg        <= '0;
            state_reg       <= ST_SEARCH;
            good_cnt_reg    <= '0;
            locked_reg      <= 1'b0;
            video_reg       <= 1'b0;
            frame_start_reg <= 1'b0;
            sync_err_reg    <= 1'b0;
        end else begin
            hs_d_reg        <= hsync_in;
            vs_d_reg        <= vsync_in;
            hcnt_reg        <= hcnt_next;
            vcnt_reg        <= vcnt_next;
            hper_reg        <= hper_next;
            vper_reg        <= vper_next;
            state_reg       <= state_next;
            good_cnt_reg    <= good_cnt_next;
            locked_reg      <= locked_next;
            video_reg       <= video_next;
            frame_start_reg <= frame_start_next;
            sync_err_reg    <= sync_err_next;
        end
    end

    assign x_loc       = hcnt_reg;
    assign y_loc       = vcnt_reg;
    assign locked      = locked_reg;
    assign video       = video_reg;
    assign frame_start = frame_start_reg;
    assign sync_err    = sync_err_reg;
endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder on a small 16x12 mode: scenario table plus a per-clock
// event-based reference model; honours VGA_DEC_FLYWHEEL_EN when defined.
module tb_vga_sync_decoder;
    localparam int HD = 8, HFP = 2, HSW = 3, HBP = 3;
    localparam int VD = 5, VFP = 2, VSW = 2, VBP = 3;
    localparam int LF = 2;
    localparam int HT = HD + HFP + HSW + HBP;
    localparam int VT = VD + VFP + VSW + VBP;
    localparam int HSS = HD + HFP;
    localparam int VSS = VD + VFP;
    localparam int K_CLEAN = 0, K_EARLY = 1, K_TIMEOUT = 2, K_SHORT = 3, K_RESET = 4, K_RANDOM = 5;
    localparam int M_SEARCH = 0, M_ACQ = 1, M_LOCK = 2;
`ifdef VGA_DEC_FLYWHEEL_EN
    localparam bit FLY = 1'b1;
`else
    localparam bit FLY = 1'b0;
`endif

    typedef struct {
        int kind;
        int frames;
        int exp_lock_vf;
        int exp_errs;
        int exp_locked_end;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset, hsync_in, vsync_in;
    logic [15:0] x_loc, y_loc;
    logic        video, locked, frame_start, sync_err;

    always #5 clk = ~clk;

    vga_sync_decoder #(
        .H_display(HD), .H_front_porch(HFP), .H_sync_width(HSW), .H_back_porch(HBP),
        .V_display(VD), .V_front_porch(VFP), .V_sync_width(VSW), .V_back_porch(VBP),
        .LOCK_FRAMES(LF)
    ) dut (
        .clk(clk), .reset(reset), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .x_loc(x_loc), .y_loc(y_loc), .video(video), .locked(locked),
        .frame_start(frame_start), .sync_err(sync_err)
    );

    int n_vec = 0, n_miss = 0;

    // Reference model: positions are anchored to the clock index of the last accepted sync,
    // periods are differences between event timestamps.
    int m_t = 0, m_xa = 0, m_xb = 0, m_yb = 0, m_ywr = 0, m_lasthf = 0, m_hfcnt = 0;
    int m_st = M_SEARCH, m_good = 0, m_miss = 0;
    bit m_phs = 1'b1, m_pvs = 1'b1;
    int e_x = 0, e_y = 0;
    bit e_vid = 1'b0, e_lock = 1'b0, e_fs = 1'b0, e_err = 1'b0;

    // Scenario bookkeeping
    int sh, sv, frame_idx, vtot_cur, cur_kind, line_shift;
    int vf_count, lock_vf, err_count, fs_count, vid_acc;
    bit seen_fs;

    task automatic model_step(input logic hs, input logic vs, input logic rst);
        bit hf, vf, coast, bad_line, tmo, frame_ok, drop;
        int gap;
        m_t++;
        e_err = 1'b0;
        if (rst) begin
            m_xa = m_t; m_xb = 0; m_yb = 0; m_ywr = 0;
            m_lasthf = m_t; m_hfcnt = 0;
            m_st = M_SEARCH; m_good = 0; m_miss = 0;
            m_phs = 1'b1; m_pvs = 1'b1;
            e_x = 0; e_y = 0; e_vid = 1'b0; e_lock = 1'b0; e_fs = 1'b0;
        end else begin
            hf = m_phs && !hs;
            vf = m_pvs && !vs;
            coast = FLY && (m_st == M_LOCK);
            gap = m_t - m_lasthf;
            bad_line = hf && (gap != HT);
            tmo = (gap - 1 == 2 * HT);
            frame_ok = (m_hfcnt == VT);
            if (hf && !coast) begin
                m_xa = m_t; m_xb = HSS;
            end
            e_x = (m_xb + m_t - m_xa) % HT;
            if (vf && !coast) begin
                m_yb = VSS; m_ywr = 0;
            end else if (e_x == 0) begin
                m_ywr++;
            end
            e_y = (m_yb + m_ywr) % VT;
            if (hf) m_lasthf = m_t;
            if (vf) m_hfcnt = hf ? 1 : 0;
            else if (hf) m_hfcnt++;
            if (m_st == M_SEARCH) begin
                m_miss = 0;
                if (vf) begin m_st = M_ACQ; m_good = 0; end
            end else if (m_st == M_ACQ) begin
                m_miss = 0;
                if (bad_line || tmo) m_st = M_SEARCH;
                else if (vf && frame_ok) begin
                    m_good++;
                    if (m_good == LF) m_st = M_LOCK;
                end else if (vf) m_good = 0;
            end else begin
                drop = tmo || (vf && !frame_ok);
                if (FLY) begin
                    if (hf) m_miss = bad_line ? m_miss + 1 : 0;
                    drop = drop || (m_miss >= 4);
                end else begin
                    drop = drop || bad_line;
                end
                if (drop) begin m_st = M_SEARCH; m_miss = 0; e_err = 1'b1; end
            end
            m_phs = hs; m_pvs = vs;
            e_lock = (m_st == M_LOCK);
            e_vid = e_lock && (e_x < HD) && (e_y < VD);
            e_fs = e_lock && (e_x == 0) && (e_y == 0);
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One clock: drive at the falling edge, let the rising edge happen, compare at the next falling edge.
    task automatic cycle(input logic hs, input logic vs, input logic rst);
        bit vf_gen, was_locked;
        vf_gen = !rst && m_pvs && !vs;
        was_locked = locked;
        hsync_in = hs; vsync_in = vs; reset = rst;
        model_step(hs, vs, rst);
        @(posedge clk);
        @(negedge clk);
        n_vec++;
        if ({x_loc, y_loc, video, locked, frame_start, sync_err} !==
            {16'(e_x), 16'(e_y), e_vid, e_lock, e_fs, e_err}) begin
            n_miss++;
            $display("FAIL model t=%0d x=%0d/%0d y=%0d/%0d video=%0b/%0b locked=%0b/%0b fs=%0b/%0b err=%0b/%0b",
                     m_t, x_loc, e_x, y_loc, e_y, video, e_vid, locked, e_lock,
                     frame_start, e_fs, sync_err, e_err);
        end
        if (rst) begin vf_count = 0; lock_vf = -1; end
        if (vf_gen) vf_count++;
        if (!was_locked && locked === 1'b1 && lock_vf < 0) lock_vf = vf_gen ? vf_count : -vf_count - 100;
        if (sync_err === 1'b1) err_count++;
        if (frame_start === 1'b1) begin
            if (seen_fs && cur_kind == K_CLEAN) chk("video clocks per frame", vid_acc, HD * VD);
            seen_fs = 1'b1; vid_acc = 0; fs_count++;
        end
        if (video === 1'b1) vid_acc++;
    endtask

    task automatic src_cycle(input int hshift, input bit hold_h, input bit rst);
        logic hs, vs;
        int hp;
        hp = sh + hshift;
        hs = !(hp >= HSS && hp < HSS + HSW) || hold_h;
        vs = !(sv >= VSS && sv < VSS + VSW);
        cycle(hs, vs, rst);
        if (cur_kind == K_CLEAN && locked === 1'b1) begin
            chk("x_loc tracks source", int'(x_loc), sh);
            chk("y_loc tracks source", int'(y_loc), sv);
        end
        sh++;
        if (sh == HT) begin
            sh = 0; sv++;
            if (sv == vtot_cur) begin sv = 0; frame_idx++; vtot_cur = VT; end
        end
    endtask

    task automatic run_scenario(input int idx, input vec_t v);
        int gl, rc, shift;
        bit hold, rst, did_reset;
        cur_kind = v.kind; err_count = 0; fs_count = 0; seen_fs = 1'b0; vid_acc = 0;
        sh = 0; sv = 0; frame_idx = 0; line_shift = 0; did_reset = 1'b0;
        vtot_cur = (v.kind == K_SHORT) ? VT - 1 : VT;
        gl = $urandom_range(1, 2);
        rc = $urandom_range(0, HT - 1);
        if (v.kind != K_TIMEOUT) gl = $urandom_range(1, 4);
        repeat (3) cycle(1'b1, 1'b1, 1'b1);
        while (frame_idx < v.frames) begin
            shift = 0; hold = 1'b0; rst = 1'b0;
            if (v.kind == K_EARLY && frame_idx == 3 && sv == gl) shift = 5;
            if (v.kind == K_TIMEOUT && frame_idx == 3 && sv >= gl && sv < gl + 4) hold = 1'b1;
            if (v.kind == K_RESET && frame_idx == 3 && sv == gl && sh == rc && !did_reset) begin
                chk("locked before mid-frame reset", int'(locked), 1);
                rst = 1'b1; did_reset = 1'b1;
            end
            if (v.kind == K_RANDOM) begin
                if (sh == 0) line_shift = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 3) : 0;
                if (sh == 0 && line_shift != 0 && $urandom_range(0, 1) == 1) line_shift = -line_shift;
                shift = line_shift;
            end
            src_cycle(shift, hold, rst);
            if (rst) begin
                chk("x_loc after reset", int'(x_loc), 0);
                chk("y_loc after reset", int'(y_loc), 0);
                chk("flags after reset", int'({video, locked, frame_start, sync_err}), 0);
            end
        end
        if (v.exp_lock_vf >= 0) chk("vfall count at lock", lock_vf, v.exp_lock_vf);
        if (v.exp_errs >= 0) chk("sync_err pulses", err_count, v.exp_errs);
        if (v.exp_locked_end >= 0) chk("locked at end", int'(locked), v.exp_locked_end);
        if (v.kind == K_CLEAN) chk("frame_start pulses", fs_count, 2);
        $display("scenario %0d kind %0d: first lock at vfall %0d, sync_err pulses %0d, locked %0b",
                 idx, v.kind, lock_vf, err_count, locked);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[6];
        tbl[0] = '{K_CLEAN,   5, 3, 0, 1};
        tbl[1] = '{K_EARLY,   6, 3, FLY ? 0 : 1, 1};
        tbl[2] = '{K_TIMEOUT, 6, 3, 1, 1};
        tbl[3] = '{K_SHORT,   5, 4, 0, 1};
        tbl[4] = '{K_RESET,   6, 3, 0, 1};
        tbl[5] = '{K_RANDOM,  8, -1, -1, -1};
        reset = 1'b1; hsync_in = 1'b1; vsync_in = 1'b1;
        cur_kind = K_CLEAN; vf_count = 0; lock_vf = -1; err_count = 0;
        fs_count = 0; vid_acc = 0; seen_fs = 1'b0;
        @(negedge clk);
        repeat (3) cycle(1'b1, 1'b1, 1'b1);
        chk("reset x_loc", int'(x_loc), 0);
        chk("reset y_loc", int'(y_loc), 0);
        chk("reset video", int'(video), 0);
        chk("reset locked", int'(locked), 0);
        chk("reset sync_err", int'(sync_err), 0);
        chk("reset frame_start", int'(frame_start), 0);
        for (int i = 0; i < 6; i++) run_scenario(i, tbl[i]);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
